// File: rtl/clk_gate_seq_if.sv
// Bundle between the clock-gate sequencer and its environment: control mask,
// per-peripheral idle handshake, applied enables and timeout status.
interface clk_gate_seq_if #(
  parameter int NUM_PERIPH = 32
);
  logic [NUM_PERIPH-1:0] clk_gate_i;
  logic [NUM_PERIPH-1:0] idle_ack_i;
  logic                  timeout_clr_i;
  logic [NUM_PERIPH-1:0] idle_req_o;
  logic [NUM_PERIPH-1:0] clk_en_o;
  logic                  busy_o;
  logic [NUM_PERIPH-1:0] timeout_o;

  modport master (
    output clk_gate_i, idle_ack_i, timeout_clr_i,
    input  idle_req_o, clk_en_o, busy_o, timeout_o
  );

  modport slave (
    input  clk_gate_i, idle_ack_i, timeout_clr_i,
    output idle_req_o, clk_en_o, busy_o, timeout_o
  );
endinterface

// File: rtl/clk_gate_seq.sv
// Round-robin clock-gate sequencer: idle handshake before gating, settle wait after ungating.
// Outputs registered, one cycle after detection; waits up to ACK_TIMEOUT cycles per gate request.
module clk_gate_seq #(
  parameter int NUM_PERIPH    = 32,
  parameter int ACK_TIMEOUT   = 255,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic           HCLK,
  input  logic           HRESET,
  clk_gate_seq_if.slave  bus
);
  localparam int IDX_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SETTLE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_PERIPH-1:0] clk_en_q, clk_en_d;
  logic [NUM_PERIPH-1:0] idle_req_q, idle_req_d;
  logic [NUM_PERIPH-1:0] timeout_q, timeout_d;

  logic [NUM_PERIPH-1:0] pending;
  logic                  found;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W:0]        pos;

  // Timed-out bits stay out of the scan until software clears their flag.
  assign pending = (bus.clk_gate_i ^ clk_en_q) & ~timeout_q;

  always_comb begin : pick
    found   = 1'b0;
    sel_idx = '0;
    pos     = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      pos = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_PERIPH)) pos = pos - (IDX_W+1)'(NUM_PERIPH);
      if (!found && pending[pos[IDX_W-1:0]]) begin
        found   = 1'b1;
        sel_idx = pos[IDX_W-1:0];
      end
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    clk_en_d   = clk_en_q;
    idle_req_d = idle_req_q;
    timeout_d  = timeout_q & ~{NUM_PERIPH{bus.timeout_clr_i}};
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d = sel_idx;
          cnt_d = '0;
          if (bus.clk_gate_i[sel_idx]) begin
            clk_en_d[sel_idx] = 1'b1;
            state_d           = S_SETTLE;
          end else begin
            idle_req_d[sel_idx] = 1'b1;
            state_d             = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.idle_ack_i[idx_q]) begin
          clk_en_d[idx_q] = 1'b0;
          state_d         = S_DONE;
        end else if (cnt_q == CNT_WIDTH'(ACK_TIMEOUT - 1)) begin
          idle_req_d[idx_q] = 1'b0;
          timeout_d[idx_q]  = 1'b1;
          state_d           = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_WIDTH'(SETTLE_CYCLES - 1)) begin
          idle_req_d[idx_q] = 1'b0;
          state_d           = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        ptr_d   = (idx_q == IDX_W'(NUM_PERIPH - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      clk_en_q   <= '1;
      idle_req_q <= '0;
      timeout_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      idle_req_q <= idle_req_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.clk_en_o   = clk_en_q;
  assign bus.idle_req_o = idle_req_q;
  assign bus.timeout_o  = timeout_q;
  assign bus.busy_o     = (state_q != S_IDLE);
endmodule
